// File: rtl/prog_memory_pkg.sv
// Shared definitions for the writable program memory.
// FSM state encodings, the LED opcode and the default NOP/LED word.
package prog_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } pm_state_e;

    localparam logic [3:0] OP_LED = 4'hD;

    // Returned for out-of-range fetches and corrupted words.
    localparam logic [27:0] PM_DEFAULT_WORD = {OP_LED, 24'b10101010};

    function automatic int bytes_per_word(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_byte_packer.sv
// Assembles big-endian loader bytes into instruction words.
// Ports: clk, rst_n, clear, byte_valid/byte_in in; word_valid/word out.
module prog_byte_packer
    import prog_memory_pkg::*;
#(
    parameter int DATA_WIDTH     = 28,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        // Shifting left and truncating drops the excess high bits
        // of the first byte once the full word has been shifted in.
        word       = DATA_WIDTH'({sh_q, byte_in});
        word_valid = byte_valid && (cnt_q == LAST);
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        if (clear) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (byte_valid) begin
            sh_d  = word;
            cnt_d = word_valid ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/prog_memory.sv
// Writable program memory: synchronous fetch port plus byte-serial loader.
// Ports: Clock, Reset(n), iAddress/oInstruction(+Valid), iLoad*/oLoad*,
// oLoading (CPU stall), oParityError. Option: PROG_MEMORY_PARITY_EN.
module prog_memory
    import prog_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 28,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD =
        DATA_WIDTH'(PM_DEFAULT_WORD)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [ADDR_WIDTH-1:0]  iAddress,
    output logic [DATA_WIDTH-1:0]  oInstruction,
    output logic                   oInstructionValid,
    input  logic                   iLoadStart,
    input  logic [$clog2(DEPTH):0] iLoadWords,
    input  logic [7:0]             iLoadByte,
    input  logic                   iLoadValid,
    output logic                   oLoadReady,
    output logic                   oLoading,
    output logic                   oLoadDone,
    output logic                   oParityError
);

    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pm_state_e             state_q, state_d;
    logic [IW-1:0]         wr_addr_q, wr_addr_d;
    logic [CW-1:0]         remain_q, remain_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;
    logic                  perr_q, perr_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  start;
    logic                  byte_acc;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic                  wr_en;
    logic                  in_range;
    logic                  rd_bad;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign start    = (state_q == ST_IDLE) && iLoadStart;
    assign byte_acc = iLoadValid && loading_q;

    prog_byte_packer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_packer (
        .clk        (Clock),
        .rst_n      (Reset),
        .clear      (start),
        .byte_valid (byte_acc),
        .byte_in    (iLoadByte),
        .word_valid (word_valid),
        .word       (word)
    );

    assign in_range = 32'(iAddress) < DEPTH;
    assign rd_idx   = IW'(iAddress);

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr_q] <= word;
        end
    end

`ifdef PROG_MEMORY_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_par[wr_addr_q] <= ^word;
        end
    end

    assign rd_bad = in_range &&
                    ((^mem[rd_idx]) != mem_par[rd_idx]);
`else
    assign rd_bad = 1'b0;
`endif

    assign rd_word = (!in_range || rd_bad) ? DEFAULT_WORD
                                           : mem[rd_idx];

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        remain_d  = remain_q;
        wr_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iLoadStart) begin
                    wr_addr_d = '0;
                    if (iLoadWords == '0) begin
                        remain_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        remain_d = (iLoadWords > DEPTH_C) ? DEPTH_C
                                                          : iLoadWords;
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + IW'(1);
                    remain_d  = remain_q - CW'(1);
                    if (remain_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A fetch is registered only on edges that neither sit
        // inside a load nor enter one; otherwise the output holds.
        valid_d   = (state_q != ST_LOAD) && (state_d != ST_LOAD);
        instr_d   = valid_d ? rd_word : instr_q;
        perr_d    = valid_d && rd_bad;
        loading_d = (state_d == ST_LOAD);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            remain_q  <= '0;
            instr_q   <= DEFAULT_WORD;
            valid_q   <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            remain_q  <= remain_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
        end
    end

    assign oInstruction      = instr_q;
    assign oInstructionValid = valid_q;
    assign oLoadReady        = loading_q;
    assign oLoading          = loading_q;
    assign oLoadDone         = done_q;
    assign oParityError      = perr_q;

endmodule

// File: tb/tb_prog_memory.sv
// Scoreboard bench for prog_memory: directed loads and fetches.
// Define PROG_MEMORY_PARITY_EN to also exercise parity checking.
module tb_prog_memory;

    localparam logic [27:0] DEF = 28'hD0000AA;

    typedef struct packed {
        logic [27:0] instr;
        logic        perr;
    } rd_exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] iAddress = '0;
    logic [27:0] oInstruction;
    logic        oInstructionValid;
    logic        iLoadStart = 1'b0;
    logic [8:0]  iLoadWords = '0;
    logic [7:0]  iLoadByte = '0;
    logic        iLoadValid = 1'b0;
    logic        oLoadReady;
    logic        oLoading;
    logic        oLoadDone;
    logic        oParityError;

    int n_chk = 0;
    int n_fail = 0;

    rd_exp_t rd_q[$];
    logic    rd_tag = 1'b0;
    logic    rd_tag_q = 1'b0;

    always #5 Clock = ~Clock;

    prog_memory dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iAddress          (iAddress),
        .oInstruction      (oInstruction),
        .oInstructionValid (oInstructionValid),
        .iLoadStart        (iLoadStart),
        .iLoadWords        (iLoadWords),
        .iLoadByte         (iLoadByte),
        .iLoadValid        (iLoadValid),
        .oLoadReady        (oLoadReady),
        .oLoading          (oLoading),
        .oLoadDone         (oLoadDone),
        .oParityError      (oParityError)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Tags the cycle whose edge samples a scoreboarded address.
    always @(posedge Clock) rd_tag_q <= rd_tag;

    // Monitor: compares the registered fetch against the queue.
    always @(negedge Clock) begin
        if (rd_tag_q) begin
            rd_exp_t e;
            n_chk++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL read: unexpected output %h", oInstruction);
            end else begin
                e = rd_q.pop_front();
                if (oInstructionValid !== 1'b1 ||
                    oInstruction !== e.instr ||
                    oParityError !== e.perr) begin
                    n_fail++;
                    $display("FAIL read: got v=%b d=%h pe=%b expected v=1 d=%h pe=%b",
                             oInstructionValid, oInstruction,
                             oParityError, e.instr, e.perr);
                end
            end
        end
    end

    task automatic rd(input logic [15:0] a, input logic [27:0] d,
                      input logic pe);
        iAddress = a;
        rd_q.push_back('{instr: d, perr: pe});
        rd_tag = 1'b1;
        @(negedge Clock);
        rd_tag = 1'b0;
    endtask

    task automatic start_load(input logic [8:0] n);
        iLoadStart = 1'b1;
        iLoadWords = n;
        @(negedge Clock);
        iLoadStart = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        iLoadValid = 1'b1;
        iLoadByte = b;
        @(negedge Clock);
        iLoadValid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " instr"}, 32'(oInstruction), 32'(DEF));
        chk({tag, " valid"}, 32'(oInstructionValid), 32'd0);
        chk({tag, " ready"}, 32'(oLoadReady), 32'd0);
        chk({tag, " loading"}, 32'(oLoading), 32'd0);
        chk({tag, " done"}, 32'(oLoadDone), 32'd0);
        chk({tag, " perr"}, 32'(oParityError), 32'd0);
    endtask

    logic [7:0] v1 [8] = '{8'hF1, 8'h00, 8'h00, 8'h0F,
                           8'h02, 8'h05, 8'h00, 8'h00};
    logic [7:0] v2 [8] = '{8'h1A, 8'hBC, 8'hDE, 8'hF0,
                           8'h03, 8'h33, 8'h44, 8'h55};

    initial begin
        // Reset state and out-of-range fetch.
        @(negedge Clock);
        @(negedge Clock);
        chk_reset_outs("reset");
        Reset = 1'b1;
        rd(16'd300, DEF, 1'b0);

        // Back-to-back two-word load.
        start_load(9'd2);
        chk("load1 loading", 32'(oLoading), 32'd1);
        chk("load1 ready", 32'(oLoadReady), 32'd1);
        chk("load1 ivalid", 32'(oInstructionValid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            iLoadValid = 1'b1;
            iLoadByte = v1[i];
            @(negedge Clock);
            if (i == 6)
                chk("load1 busy", 32'(oLoading), 32'd1);
        end
        iLoadValid = 1'b0;
        chk("load1 done", 32'(oLoadDone), 32'd1);
        chk("load1 loading end", 32'(oLoading), 32'd0);
        chk("load1 ready end", 32'(oLoadReady), 32'd0);
        rd(16'd1, 28'h2050000, 1'b0);
        chk("load1 done pulse", 32'(oLoadDone), 32'd0);
        rd(16'd0, 28'h100000F, 1'b0);

        // Load with idle gaps and a stray start mid-load.
        start_load(9'd2);
        for (int i = 0; i < 8; i++) begin
            send(v2[i]);
            iLoadStart = (i == 3);
            iLoadWords = '0;
            @(negedge Clock);
            iLoadStart = 1'b0;
            if (i < 7) begin
                chk("gap loading", 32'(oLoading), 32'd1);
                chk("gap ivalid", 32'(oInstructionValid), 32'd0);
            end
        end
        rd(16'd0, 28'hABCDEF0, 1'b0);
        rd(16'd1, 28'h3334455, 1'b0);

        // Zero-word load.
        start_load(9'd0);
        chk("zero done", 32'(oLoadDone), 32'd1);
        chk("zero loading", 32'(oLoading), 32'd0);
        rd(16'd0, 28'hABCDEF0, 1'b0);

        // Oversized count saturates to the full depth.
        start_load(9'd300);
        for (int w = 0; w < 256; w++) begin
            send(8'h07);
            send(8'h00);
            send(8'h00);
            if (w == 255)
                chk("sat busy", 32'(oLoading), 32'd1);
            send(8'(w));
        end
        chk("sat done", 32'(oLoadDone), 32'd1);
        rd(16'd255, 28'h70000FF, 1'b0);
        rd(16'd256, DEF, 1'b0);
        rd(16'd0, 28'h7000000, 1'b0);

        // Reset in the middle of the second word.
        start_load(9'd2);
        send(8'h01); send(8'h23); send(8'h45); send(8'h67);
        send(8'h0F); send(8'hFF); send(8'hFF);
        Reset = 1'b0;
        #1;
        chk_reset_outs("midreset");
        @(negedge Clock);
        Reset = 1'b1;
        rd(16'd0, 28'h1234567, 1'b0);
        rd(16'd1, 28'h7000001, 1'b0);

        // Fresh load after reset assembles from a clean counter.
        start_load(9'd1);
        send(8'h09); send(8'h87); send(8'h65); send(8'h43);
        chk("post reset done", 32'(oLoadDone), 32'd1);
        rd(16'd0, 28'h9876543, 1'b0);
        rd(16'd1, 28'h7000001, 1'b0);

`ifdef PROG_MEMORY_PARITY_EN
        dut.mem[5] = dut.mem[5] ^ 28'h1;
        rd(16'd5, DEF, 1'b1);
        rd(16'd6, 28'h7000006, 1'b0);
        rd(16'd300, DEF, 1'b0);
`endif

        @(negedge Clock);
        @(negedge Clock);
        chk("scoreboard drained", 32'(rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_memory.md
# prog_memory

Parametrised, writable program memory for the single-cycle CPU: the successor of the hard-coded combinational instruction ROM. The CPU fetches from it through a synchronous read port. A byte-serial loader port (fed by the UART receiver) writes a program of N words without resynthesis. While loading, the block raises a stall indication so the CPU holds its PC.

## Interface
- `DATA_WIDTH`, default 28: instruction word width. Matches the `{opcode, dst, src0, src1}` format.
- `DEPTH`, default 256: number of stored words.
- `ADDR_WIDTH`, default 16: fetch address width, matching the CPU PC.
- `DEFAULT_WORD`, default `{LED, 24'b10101010}`: returned for out-of-range addresses and for parity errors.
- Localparam `BYTES_PER_WORD = ceil(DATA_WIDTH/8)`, which is 4 for the defaults.
- `Clock`, input, 1 bit: single clock. All logic is rising-edge.
- `Reset`, input, 1 bit: asynchronous, active-low reset.
- `iAddress`, input, `ADDR_WIDTH`: fetch address.
- `oInstruction`, output, `DATA_WIDTH`: registered fetch data.
- `oInstructionValid`, output, 1 bit: `oInstruction` is valid for the address sampled on the previous edge.
- `iLoadStart`, input, 1 bit: pulse that starts a load at address 0.
- `iLoadWords`, input, `clog2(DEPTH)+1`: word count, latched on `iLoadStart`.
- `iLoadByte`, input, 8 bits: loader data byte.
- `iLoadValid`, input, 1 bit: `iLoadByte` is valid.
- `oLoadReady`, output, 1 bit: loader can accept a byte.
- `oLoading`, output, 1 bit: CPU stall request.
- `oLoadDone`, output, 1 bit: one-cycle pulse at the end of a load.
- `oParityError`, output, 1 bit: the registered read had a parity mismatch.

## Operation
- The FSM has three states: IDLE, LOAD, DONE.
- **IDLE**
  - Every edge registers `mem[iAddress]` into `oInstruction`. If `iAddress >= DEPTH`, it registers `DEFAULT_WORD` instead.
  - `oInstructionValid` is 1 from the second cycle after reset release.
  - `iLoadValid` is ignored.
  - `iLoadStart` with `iLoadWords == 0` goes to DONE.
  - `iLoadStart` with `iLoadWords > DEPTH` saturates the count to `DEPTH`.
  - Otherwise, `iLoadStart` latches the count, clears the write address and byte counter, and goes to LOAD.
- **LOAD**
  - `oLoading = 1`, `oLoadReady = 1`, `oInstructionValid = 0`. `oInstruction` holds its last value.
  - A byte is accepted when `iLoadValid && oLoadReady`.
  - Bytes are big-endian: the first byte is the most significant. High bits beyond `DATA_WIDTH` in the first byte are discarded (top 4 bits for the defaults).
  - On the `BYTES_PER_WORD`-th byte, the assembled word is written to `mem[wrAddr]`, `wrAddr` increments and the remaining count decrements. When the count reaches 0, the FSM goes to DONE.
  - `iLoadStart` is ignored.
- **DONE** lasts one cycle:
  - `oLoadDone = 1`, `oLoading = 0`, `oLoadReady = 0`.
  - The read of `iAddress` is registered in this cycle.
  - Next state is IDLE.
- Reset mid-load: FSM goes to IDLE and counters clear. A partially assembled word is discarded. Words already written remain.
- Memory contents are never reset.

## Timing
- Reset values: `oInstruction = DEFAULT_WORD`; `oInstructionValid`, `oLoadReady`, `oLoading`, `oLoadDone`, `oParityError` all 0.
- Read latency is 1 cycle: address at edge k gives data and valid after edge k.
- `oLoading` rises on the edge that samples `iLoadStart`.
- Write occurs on the edge accepting the last byte of a word. DONE follows on that same edge when it is the final word.
- Read-after-load: the first IDLE-registered read already sees the newly written contents.
- Back-to-back bytes on consecutive cycles are supported. There is no throughput limit.

## Configuration
- `PROG_MEMORY_PARITY_EN` defined:
  - Each stored word carries an even-parity bit, computed at write.
  - On read, a mismatch sets `oParityError = 1` for that cycle and replaces `oInstruction` with `DEFAULT_WORD`.
  - Out-of-range reads never flag an error.
- Not defined: no parity storage, and `oParityError` is tied to 0.

## Structure
- Shared package/include:
  - FSM state encodings (IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2).
  - The default NOP/LED word.
  - Opcode and register constants, which stay in the existing definitions include.
- One sub-module, `prog_byte_packer`:
  - Contains the byte counter and shift register.
  - Emits `wordValid`/`word` on the last byte.
  - Cleared by a start or reset.

## Test plan
- Reset, then `iAddress = 300` with default `DEPTH` → `oInstruction = DEFAULT_WORD`, valid on the second cycle after release.
- `iLoadStart`, `iLoadWords = 2`, bytes `0xF1 0x00 0x00 0x0F 0x02 0x05 0x00 0x00` → `mem[0] = 28'h100000F`, `mem[1] = 28'h2050000`. `oLoadDone` pulses one cycle after the 8th byte. Reading address 1 then returns `28'h2050000`.
- Load with gaps on `iLoadValid` (idle cycles between bytes) → same contents. `oLoading` stays high throughout.
- `iLoadWords = 0` → `oLoadDone` the next cycle, no write, `oLoading` never asserted.
- Assert `Reset` after 3 bytes of word 1 (second word) → `mem[0]` holds the new value, `mem[1]` is unchanged, all outputs are at reset values.
- With `PROG_MEMORY_PARITY_EN`, force a stored bit flip at address 5 and read it → `oParityError = 1`, `oInstruction = DEFAULT_WORD`. Reading address 6 → `oParityError = 0`.
